elastic_fifo: RTL and testbench

Parametric, data-carrying elastic FIFO with registered storage, placed directly upstream of a tail elastic buffer in a handshake channel. It absorbs bursts of up to NUM_SLOTS tokens and drives the buffer's input with a valid/ready handshake. Its output valid and data come only from storage, so it never adds a combinational valid/data path from `ins` to `outs`. It is typically paired with the downstream tail buffer, whose registered ready keeps this block's ins_ready path short.

---
 rtl/elastic_fifo.sv | 91 +++++++++
 tb/tb_elastic_fifo.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/elastic_fifo.sv
// elastic_fifo: registered-storage handshake FIFO that sits in front of a
// tail elastic buffer. Output valid/data come only from flops, so there is
// no combinational path from the input side to the output side.
module elastic_fifo #(
    parameter int DATA_TYPE = 32,
    parameter int NUM_SLOTS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_TYPE-1:0] ins,
    input  logic                 ins_valid,
    output logic                 ins_ready,
    output logic [DATA_TYPE-1:0] outs,
    output logic                 outs_valid,
    input  logic                 outs_ready
);

    localparam int PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CNT_W = $clog2(NUM_SLOTS + 1);

    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_SLOTS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(NUM_SLOTS);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    logic [DATA_TYPE-1:0] mem_q [NUM_SLOTS];
    logic [DATA_TYPE-1:0] mem_d [NUM_SLOTS];
    logic [PTR_W-1:0]     head_q, head_d;
    logic [PTR_W-1:0]     tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;

    logic full;
    logic empty;
    logic push;
    logic pop;

    // Handshake flags; ready only looks at outs_ready through the full term
    always_comb begin
        full       = (count_q == FULL_CNT);
        empty      = (count_q == '0);
        ins_ready  = ~full | outs_ready;
        outs_valid = ~empty;
        outs       = mem_q[head_q];
        push       = ins_valid & ins_ready;
        pop        = outs_valid & outs_ready;
    end

    // Next-state for pointers, occupancy and storage; pointers wrap at the last slot
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        mem_d   = mem_q;

        if (push) begin
            mem_d[tail_q] = ins;
            tail_d = (tail_q == LAST_IDX) ? '0 : tail_q + PTR_ONE;
        end

        if (pop) begin
            head_d = (head_q == LAST_IDX) ? '0 : head_q + PTR_ONE;
        end

        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Control state with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is never cleared; writes are suppressed while reset is asserted
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: tb/tb_elastic_fifo.sv
// tb_elastic_fifo: directed checks on a 4-deep instance plus a scoreboarded
// random run on a 3-deep instance to exercise non-power-of-two wrap.
module tb_elastic_fifo;

    logic       clk;
    int         checkCount;
    int         failCount;

    // 4-deep instance signals
    logic       a_rst;
    logic [7:0] a_ins;
    logic       a_ins_valid;
    logic       a_ins_ready;
    logic [7:0] a_outs;
    logic       a_outs_valid;
    logic       a_outs_ready;

    // 3-deep instance signals
    logic       b_rst;
    logic [7:0] b_ins;
    logic       b_ins_valid;
    logic       b_ins_ready;
    logic [7:0] b_outs;
    logic       b_outs_valid;
    logic       b_outs_ready;

    elastic_fifo #(.DATA_TYPE(8), .NUM_SLOTS(4)) dut4 (
        .clk        (clk),
        .rst        (a_rst),
        .ins        (a_ins),
        .ins_valid  (a_ins_valid),
        .ins_ready  (a_ins_ready),
        .outs       (a_outs),
        .outs_valid (a_outs_valid),
        .outs_ready (a_outs_ready)
    );

    elastic_fifo #(.DATA_TYPE(8), .NUM_SLOTS(3)) dut3 (
        .clk        (clk),
        .rst        (b_rst),
        .ins        (b_ins),
        .ins_valid  (b_ins_valid),
        .ins_ready  (b_ins_ready),
        .outs       (b_outs),
        .outs_valid (b_outs_valid),
        .outs_ready (b_outs_ready)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drive the 4-deep instance inputs and let combinational outputs settle
    task automatic applyStimulus(input logic iv, input logic [7:0] d, input logic ordy);
        a_ins_valid  = iv;
        a_ins        = d;
        a_outs_ready = ordy;
        #1;
    endtask

    // Advance one clock, landing just after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push a token into the 4-deep instance with downstream stalled
    task automatic pushA(input logic [7:0] d);
        applyStimulus(1'b1, d, 1'b0);
        checkOutput("push_ready", a_ins_ready, 1'b1);
        tick();
    endtask

    initial begin
        logic [7:0] expSeq [6];
        logic [7:0] q [$];
        logic       iv;
        logic       ordy;
        logic [7:0] d;
        logic       expReady;
        logic       expValid;

        checkCount = 0;
        failCount  = 0;

        a_rst = 1'b0; a_ins = '0; a_ins_valid = 1'b0; a_outs_ready = 1'b0;
        b_rst = 1'b0; b_ins = '0; b_ins_valid = 1'b0; b_outs_ready = 1'b0;

        // Reset for two edges
        tick();
        tick();
        a_rst = 1'b1;
        b_rst = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("reset_valid", a_outs_valid, 1'b0);
        checkOutput("reset_ready", a_ins_ready, 1'b1);

        // Fill to full
        pushA(8'h11);
        checkOutput("first_latency_valid", a_outs_valid, 1'b1);
        checkOutput("first_latency_data", a_outs, 8'h11);
        pushA(8'h22);
        pushA(8'h33);
        pushA(8'h44);
        applyStimulus(1'b1, 8'h55, 1'b0);
        checkOutput("full_ready", a_ins_ready, 1'b0);
        checkOutput("full_head", a_outs, 8'h11);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("held_valid", a_outs_valid, 1'b1);
        checkOutput("held_data", a_outs, 8'h11);

        // Drain in order; 0x55 must not appear
        expSeq[0] = 8'h11; expSeq[1] = 8'h22; expSeq[2] = 8'h33; expSeq[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
            checkOutput("drain_valid", a_outs_valid, 1'b1);
            checkOutput("drain_data", a_outs, expSeq[i]);
            tick();
        end
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("drain_empty", a_outs_valid, 1'b0);

        // Full-throughput at full
        pushA(8'h11);
        pushA(8'h22);
        pushA(8'h33);
        pushA(8'h44);
        expSeq[4] = 8'hA0; expSeq[5] = 8'hA1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 8'hA0 + 8'(i), 1'b1);
            checkOutput("tput_ready", a_ins_ready, 1'b1);
            checkOutput("tput_valid", a_outs_valid, 1'b1);
            checkOutput("tput_data", a_outs, expSeq[i]);
            tick();
        end
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("tput_still_full", a_ins_ready, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
            checkOutput("tput_tail_data", a_outs, 8'hA2 + 8'(i));
            tick();
        end
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("tput_empty", a_outs_valid, 1'b0);

        // Empty push: no bypass
        applyStimulus(1'b1, 8'h5A, 1'b1);
        checkOutput("nobypass_valid", a_outs_valid, 1'b0);
        checkOutput("nobypass_ready", a_ins_ready, 1'b1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("nobypass_next_valid", a_outs_valid, 1'b1);
        checkOutput("nobypass_next_data", a_outs, 8'h5A);
        applyStimulus(1'b0, 8'h00, 1'b1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("nobypass_drained", a_outs_valid, 1'b0);

        // Mid-operation reset with push and pop attempted
        pushA(8'h01);
        pushA(8'h02);
        a_rst = 1'b0;
        applyStimulus(1'b1, 8'h03, 1'b1);
        tick();
        a_rst = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("midrst_valid", a_outs_valid, 1'b0);
        checkOutput("midrst_ready", a_ins_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
            checkOutput("midrst_stays_empty", a_outs_valid, 1'b0);
            tick();
        end
        applyStimulus(1'b1, 8'h04, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("midrst_fresh_data", a_outs, 8'h04);

        // Non-power-of-two wrap: random handshakes against a queue model
        for (int cyc = 0; cyc < 1000; cyc++) begin
            iv   = 1'($urandom_range(0, 1));
            ordy = 1'($urandom_range(0, 1));
            d    = 8'($urandom);
            b_ins_valid  = iv;
            b_ins        = d;
            b_outs_ready = ordy;
            #1;
            expReady = (q.size() < 3) || ordy;
            expValid = (q.size() != 0);
            checkOutput("wrap_ready", b_ins_ready, expReady);
            checkOutput("wrap_valid", b_outs_valid, expValid);
            if (expValid) begin
                checkOutput("wrap_data", b_outs, q[0]);
            end
            if (expValid && ordy) begin
                void'(q.pop_front());
            end
            if (iv && expReady) begin
                q.push_back(d);
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
